// File: rtl/therm_pkg.sv
// therm_pkg: shared defaults for the thermometer stream decoder.
//   THERM_K  : default binary output width
//   THERM_W  : default thermometer input width (2**K-1)
//   ERRC_W   : width of the error counter
//   ERRC_MAX : saturation value of the error counter
package therm_pkg;
  localparam int THERM_K = 3;
  localparam int THERM_W = (1 << THERM_K) - 1;
  localparam int ERRC_W  = 8;
  localparam logic [ERRC_W-1:0] ERRC_MAX = 8'd255;
endpackage

// File: rtl/therm_word_decode.sv
// therm_word_decode: combinational thermometer-to-binary decode + legality check.
//   word : thermometer word, bit 0 = lowest level
//   bin  : decoded level
//   err  : 1 when word is not of the form 2**n-1
// Build option THERM_BUBBLE_CORRECT_EN: when defined, an illegal word decodes
// to its popcount (bubble correction); otherwise to the length of the run of
// 1s starting at bit 0. Legal words decode identically in both builds.
module therm_word_decode
  import therm_pkg::*;
#(
  parameter int K = THERM_K,
  parameter int W = (1 << K) - 1
) (
  input  logic [W-1:0] word,
  output logic [K-1:0] bin,
  output logic         err
);

  logic [W-1:0] word_inc;

  // Legal iff no 1 sits above a 0: then word+1 shares no bits with word.
  assign word_inc = word + W'(1);
  assign err      = |(word & word_inc);

`ifdef THERM_BUBBLE_CORRECT_EN
  logic [K-1:0] ones_cnt;

  // For a legal word the popcount is the level, so one counter covers both.
  always_comb begin
    ones_cnt = '0;
    for (int i = 0; i < W; i++) ones_cnt = ones_cnt + K'(word[i]);
  end

  assign bin = ones_cnt;
`else
  logic [K-1:0] run_cnt;
  logic         run_on;

  // Length of the unbroken run of 1s from bit 0; equals the level when legal.
  always_comb begin
    run_cnt = '0;
    run_on  = 1'b1;
    for (int i = 0; i < W; i++) begin
      run_on  = run_on & word[i];
      run_cnt = run_cnt + K'(run_on);
    end
  end

  assign bin = run_cnt;
`endif

endmodule

// File: rtl/thermometer_stream_decoder.sv
// thermometer_stream_decoder: two-stage valid/ready pipeline that decodes a
// thermometer word to binary and flags illegal (bubble) words.
//   clk, rst_n          : clock, async active-low reset
//   s_therm/s_valid/s_ready : input stream
//   m_bin/m_err/m_valid/m_ready : output stream
//   clr_err             : synchronous clear of err_count (wins over increment)
//   err_count           : saturating count of delivered erroneous words
// Build option THERM_BUBBLE_CORRECT_EN selects bubble-corrected decode of
// illegal words (see therm_word_decode).
module thermometer_stream_decoder
  import therm_pkg::*;
#(
  parameter int K = THERM_K,
  parameter int W = (1 << K) - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W-1:0]      s_therm,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [K-1:0]      m_bin,
  output logic              m_err,
  output logic              m_valid,
  input  logic              m_ready,
  input  logic              clr_err,
  output logic [ERRC_W-1:0] err_count
);

  logic              v1_q, v2_q;
  logic [W-1:0]      w1_q;
  logic [K-1:0]      bin_q;
  logic              err_q;
  logic [K-1:0]      dec_bin;
  logic              dec_err;
  logic              adv1, adv2;
  logic [ERRC_W-1:0] errc_q, errc_d;

  // A stage may load whenever it is empty or its contents leave this edge.
  assign adv2    = !v2_q || m_ready;
  assign adv1    = !v1_q || adv2;
  assign s_ready = adv1;

  // Stage 1: raw word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      w1_q <= '0;
    end else if (adv1) begin
      v1_q <= s_valid;
      if (s_valid) w1_q <= s_therm;
    end
  end

  therm_word_decode #(.K(K), .W(W)) u_dec (
    .word (w1_q),
    .bin  (dec_bin),
    .err  (dec_err)
  );

  // Stage 2: decoded result, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q  <= 1'b0;
      bin_q <= '0;
      err_q <= 1'b0;
    end else if (adv2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        bin_q <= dec_bin;
        err_q <= dec_err;
      end
    end
  end

  assign m_valid = v2_q;
  assign m_bin   = bin_q;
  assign m_err   = err_q;

  // Error counter: clear has priority, increment saturates.
  always_comb begin
    errc_d = errc_q;
    if (clr_err)
      errc_d = '0;
    else if (v2_q && m_ready && err_q && errc_q != ERRC_MAX)
      errc_d = errc_q + ERRC_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) errc_q <= '0;
    else        errc_q <= errc_d;
  end

  assign err_count = errc_q;

endmodule

// File: tb/tb_thermometer_stream_decoder.sv
module tb_thermometer_stream_decoder;
  import therm_pkg::*;

  localparam int K = 3;
  localparam int W = 7;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] s_therm = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [K-1:0] m_bin;
  logic         m_err;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic         clr_err = 1'b0;
  logic [7:0]   err_count;

  thermometer_stream_decoder #(.K(K), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .s_therm(s_therm), .s_valid(s_valid),
    .s_ready(s_ready), .m_bin(m_bin), .m_err(m_err), .m_valid(m_valid),
    .m_ready(m_ready), .clr_err(clr_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [K-1:0] bin;
    logic         err;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         got;
  int           exp_errc;
  bit           fire_in, fire_out;
  logic [K-1:0] o_bin;
  logic         o_err;
  int           n_chk, n_pass;

`ifdef THERM_BUBBLE_CORRECT_EN
  localparam int BUB_EXP = 3;
`else
  localparam int BUB_EXP = 2;
`endif

  // Reference decode straight from the level definition.
  function automatic exp_t ref_dec(input logic [W-1:0] w);
    exp_t e;
    int   n, run;
    n = $countones(w);
    e.err = (int'(w) != (1 << n) - 1);
    run = 0;
    while (run < W && w[run]) run++;
`ifdef THERM_BUBBLE_CORRECT_EN
    e.bin = K'(n);
`else
    e.bin = e.err ? K'(run) : K'(n);
`endif
    return e;
  endfunction

  function automatic logic [W-1:0] rand_word(input bit bubble);
    logic [W-1:0] w;
    if (!bubble) return W'((1 << $urandom_range(0, W)) - 1);
    do w = W'($urandom); while (!ref_dec(w).err);
    return w;
  endfunction

  // Advance one cycle: record handshakes seen just before the edge and
  // update the scoreboard. Leaves time at posedge+1.
  task automatic tick();
    @(negedge clk);
    fire_in  = rst_n && s_valid && s_ready;
    fire_out = rst_n && m_valid && m_ready;
    o_bin = m_bin;
    o_err = m_err;
    if (fire_out) begin
      if (exp_q.size() == 0) begin
        got.bin = 'x;
        got.err = 1'bx;
      end else got = exp_q.pop_front();
    end
    if (fire_in) exp_q.push_back(ref_dec(s_therm));
    if (!rst_n) begin
      exp_q.delete();
      exp_errc = 0;
    end else if (clr_err) exp_errc = 0;
    else if (fire_out && got.err === 1'b1 && exp_errc < 255) exp_errc++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_chk++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid: got %b want 0", m_valid); else n_pass++;
    n_chk++; if (s_ready !== 1'b1) $display("FAIL rst_s_ready: got %b want 1", s_ready); else n_pass++;
    n_chk++; if (err_count !== 8'd0) $display("FAIL rst_err_count: got %0d want 0", err_count); else n_pass++;
    n_chk++; if ({m_bin, m_err} !== 4'b0) $display("FAIL rst_m_bin_err: got %0d/%b want 0/0", m_bin, m_err); else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n_chk++; if (s_ready !== 1'b1) $display("FAIL rst_release_s_ready: got %b want 1", s_ready); else n_pass++;
  endtask

  task automatic test_latency();
    logic [W-1:0] lw[3] = '{7'b0000111, 7'b0000000, 7'b1111111};
    int           lb[3] = '{3, 0, 7};
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_therm = lw[i];
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
      n_chk++; if (m_valid !== 1'b0) $display("FAIL lat_cycle1_valid[%0d]: got %b want 0", i, m_valid); else n_pass++;
      tick();
      n_chk++;
      if (m_valid !== 1'b1 || m_bin !== K'(lb[i]) || m_err !== 1'b0)
        $display("FAIL lat_cycle2[%0d]: got v=%b bin=%0d err=%b want v=1 bin=%0d err=0", i, m_valid, m_bin, m_err, lb[i]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_bubble();
    m_ready = 1'b1;
    s_therm = 7'b0001011;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    n_chk++;
    if (m_valid !== 1'b1 || m_err !== 1'b1 || m_bin !== K'(BUB_EXP))
      $display("FAIL bubble_out: got v=%b bin=%0d err=%b want v=1 bin=%0d err=1", m_valid, m_bin, m_err, BUB_EXP);
    else n_pass++;
    tick();
    n_chk++; if (err_count !== 8'd1) $display("FAIL bubble_err_count: got %0d want 1", err_count); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int outs;
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_therm = rand_word(1'b1);
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (m_valid !== 1'b0) $display("FAIL mid_rst_m_valid: got %b want 0", m_valid); else n_pass++;
    n_chk++; if (s_ready !== 1'b1) $display("FAIL mid_rst_s_ready: got %b want 1", s_ready); else n_pass++;
    n_chk++; if (err_count !== 8'd0) $display("FAIL mid_rst_err_count: got %0d want 0", err_count); else n_pass++;
    s_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    m_ready = 1'b1;
    n_chk++; if (s_ready !== 1'b1) $display("FAIL mid_rst_release_s_ready: got %b want 1", s_ready); else n_pass++;
    outs = 0;
    repeat (6) begin
      tick();
      if (fire_out || m_valid) outs++;
    end
    n_chk++; if (outs != 0) $display("FAIL mid_rst_stale: got %0d stale outputs want 0", outs); else n_pass++;
  endtask

  task automatic test_backpressure();
    int idx, outs, budget;
    idx = 0;
    outs = 0;
    m_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      s_valid = 1'b1;
      s_therm = W'((1 << (idx + 1)) - 1);
      tick();
      if (fire_in) idx++;
      if (t >= 1) begin
        n_chk++;
        if (m_valid !== 1'b1 || m_bin !== 3'd1)
          $display("FAIL bp_hold[%0d]: got v=%b bin=%0d want v=1 bin=1", t, m_valid, m_bin);
        else n_pass++;
      end
    end
    n_chk++; if (s_ready !== 1'b0) $display("FAIL bp_s_ready: got %b want 0", s_ready); else n_pass++;
    n_chk++; if (idx != 2) $display("FAIL bp_accepted: got %0d want 2", idx); else n_pass++;
    m_ready = 1'b1;
    budget = 0;
    while (outs < 4 && budget < 20) begin
      s_valid = (idx < 4);
      s_therm = W'((1 << (idx + 1)) - 1);
      tick();
      budget++;
      if (fire_in) idx++;
      if (fire_out) begin
        n_chk++;
        if (o_bin !== K'(outs + 1) || o_err !== 1'b0 || got.bin !== o_bin)
          $display("FAIL bp_order[%0d]: got bin=%0d err=%b want bin=%0d err=0", outs, o_bin, o_err, outs + 1);
        else n_pass++;
        outs++;
      end
    end
    s_valid = 1'b0;
    n_chk++; if (outs != 4) $display("FAIL bp_count: got %0d outputs want 4", outs); else n_pass++;
    repeat (3) tick();
    n_chk++; if (exp_q.size() != 0 || m_valid !== 1'b0) $display("FAIL bp_extra: got %0d pending, v=%b want 0,0", exp_q.size(), m_valid); else n_pass++;
  endtask

  task automatic test_saturation();
    int sent, outs, budget;
    sent = 0;
    outs = 0;
    budget = 0;
    m_ready = 1'b1;
    while (outs < 260 && budget < 400) begin
      s_valid = (sent < 260);
      s_therm = rand_word(1'b1);
      tick();
      budget++;
      if (fire_in) sent++;
      if (fire_out) outs++;
    end
    s_valid = 1'b0;
    n_chk++; if (outs != 260) $display("FAIL sat_delivered: got %0d want 260", outs); else n_pass++;
    n_chk++; if (err_count !== 8'd255) $display("FAIL sat_err_count: got %0d want 255", err_count); else n_pass++;
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_therm = rand_word(1'b1);
    tick();
    s_valid = 1'b0;
    budget = 0;
    while (m_valid !== 1'b1 && budget < 10) begin
      tick();
      budget++;
    end
    n_chk++; if (m_valid !== 1'b1 || m_err !== 1'b1) $display("FAIL sat_clr_setup: got v=%b err=%b want 1,1", m_valid, m_err); else n_pass++;
    clr_err = 1'b1;
    m_ready = 1'b1;
    tick();
    clr_err = 1'b0;
    n_chk++; if (!fire_out || err_count !== 8'd0) $display("FAIL sat_clr_wins: got fire=%b cnt=%0d want 1,0", fire_out, err_count); else n_pass++;
  endtask

  task automatic test_throughput();
    int sent, outs, first, last, bad;
    sent = 0; outs = 0; first = -1; last = -1; bad = 0;
    m_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      s_valid = (sent < 16);
      s_therm = rand_word(1'($urandom_range(0, 1)));
      if (s_valid && s_ready !== 1'b1) bad++;
      tick();
      if (fire_in) sent++;
      if (fire_out) begin
        if (first < 0) first = c;
        last = c;
        outs++;
        n_chk++;
        if (o_bin !== got.bin || o_err !== got.err)
          $display("FAIL tput_data[%0d]: got bin=%0d err=%b want bin=%0d err=%b", outs, o_bin, o_err, got.bin, got.err);
        else n_pass++;
      end
    end
    s_valid = 1'b0;
    n_chk++; if (bad != 0) $display("FAIL tput_s_ready: got %0d stalls want 0", bad); else n_pass++;
    n_chk++;
    if (outs != 16 || last - first + 1 != 16)
      $display("FAIL tput_back_to_back: got %0d outputs over %0d cycles want 16 over 16", outs, last - first + 1);
    else n_pass++;
  endtask

  task automatic test_random();
    bit           stalled;
    logic [K-1:0] pb;
    logic         pe;
    s_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!s_valid || fire_in) begin
        s_valid = ($urandom_range(0, 3) != 0);
        s_therm = rand_word(1'($urandom_range(0, 1)));
      end
      m_ready = ($urandom_range(0, 2) != 0);
      clr_err = ($urandom_range(0, 49) == 0);
      stalled = m_valid && !m_ready;
      pb = m_bin;
      pe = m_err;
      tick();
      if (fire_in) fire_in = 1'b1;
      if (fire_out) begin
        n_chk++;
        if (o_bin !== got.bin || o_err !== got.err)
          $display("FAIL rnd_data[%0d]: got bin=%0d err=%b want bin=%0d err=%b", c, o_bin, o_err, got.bin, got.err);
        else n_pass++;
      end
      if (stalled) begin
        n_chk++;
        if (m_valid !== 1'b1 || m_bin !== pb || m_err !== pe)
          $display("FAIL rnd_hold[%0d]: got v=%b bin=%0d err=%b want v=1 bin=%0d err=%b", c, m_valid, m_bin, m_err, pb, pe);
        else n_pass++;
      end
      n_chk++;
      if (err_count !== 8'(exp_errc))
        $display("FAIL rnd_err_count[%0d]: got %0d want %0d", c, err_count, exp_errc);
      else n_pass++;
    end
    s_valid = 1'b0;
    clr_err = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (fire_out) begin
        n_chk++;
        if (o_bin !== got.bin || o_err !== got.err)
          $display("FAIL rnd_drain: got bin=%0d err=%b want bin=%0d err=%b", o_bin, o_err, got.bin, got.err);
        else n_pass++;
      end
    end
    n_chk++; if (exp_q.size() != 0) $display("FAIL rnd_lost: got %0d words undelivered want 0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    exp_errc = 0;
    test_reset();
    test_latency();
    test_bubble();
    test_reset_mid();
    test_backpressure();
    test_saturation();
    test_throughput();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
